lut_cfg_loader: RTL and testbench

Word-serial configuration loader for one fracturable LUT pair (two 2^INPUTS-entry LUT halves plus one split/fracture bit). It receives a configuration frame as a valid/ready word stream from the bitstream source. It assembles the frame into a full-width configuration image, checks framing, and issues a single-cycle `cen` commit strobe with `config_out` held stable. It sits between the CLB configuration chain and the LUT's `config_in`/`cen` pins.

---
 rtl/lut_cfg_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_lut_cfg_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader.sv
// -----------------------------------------------------------------------------
// lut_cfg_loader
//
// Word-serial configuration loader for one fracturable LUT pair. A frame of
// NWORDS stream words (LSB-first) is assembled into a CFG_W-bit staging image.
// After the frame has been checked, the image is committed to config_out
// together with a one-cycle cen strobe. A malformed frame sets the sticky err
// flag and never reaches config_out.
//
// Optional feature macro: LUT_CFG_PARITY_EN
//   Defined   : each word accepted in LOAD must satisfy ^{cfg_par, cfg_data} == 0.
//   Undefined : cfg_par is ignored and no parity logic is built.
//
// Ports
//   cclk        in   configuration clock (single domain)
//   rst_n       in   synchronous active-low reset
//   start       in   begin a frame; ignored unless idle
//   cfg_valid   in   stream word valid
//   cfg_ready   out  loader accepts a word this cycle
//   cfg_data    in   stream word [WORD_W-1:0]
//   cfg_last    in   final word of the frame
//   cfg_par     in   even parity over cfg_data
//   cen         out  one-cycle commit strobe to the LUT
//   config_out  out  committed image [CFG_W-1:0]; the MSB is the split bit
//   busy        out  frame in progress (LOAD, COMMIT, DRAIN)
//   done        out  one-cycle pulse in the cycle after cen
//   err         out  sticky framing/parity error; cleared by start
// -----------------------------------------------------------------------------
module lut_cfg_loader #(
    parameter int INPUTS   = 4,
    parameter int MEM_SIZE = 2**INPUTS,
    parameter int CFG_W    = 2*MEM_SIZE+1,
    parameter int WORD_W   = 8,
    parameter int NWORDS   = (CFG_W+WORD_W-1)/WORD_W
) (
    input  logic              cclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic              cfg_par,
    output logic              cen,
    output logic [CFG_W-1:0]  config_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NWORDS-1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [WCNT_W-1:0]   wcnt_r;
    logic [CFG_W-1:0]    stage_r;
    logic [CFG_W-1:0]    config_r;
    logic                cen_r;
    logic                ready_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic [WCNT_W-1:0]   wcnt_nxt_s;
    logic [CFG_W-1:0]    stage_nxt_s;
    logic [CFG_W-1:0]    config_nxt_s;
    logic                cen_nxt_s;
    logic                ready_nxt_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                err_nxt_s;

    logic                accept_s;
    logic                final_s;
    logic                par_bad_s;
    logic [CFG_W-1:0]    stage_merge_s;

    assign cfg_ready  = ready_r;
    assign cen        = cen_r;
    assign config_out = config_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    // ready_r is a registered copy of "state is LOAD or DRAIN", so this is
    // exactly the valid/ready handshake.
    assign accept_s = cfg_valid & ready_r;
    assign final_s  = (wcnt_r == LAST_IDX);

`ifdef LUT_CFG_PARITY_EN
    // Returns 1 when {par, data} does not have even parity.
    function automatic logic parity_bad(input logic par, input logic [WORD_W-1:0] data);
        return ^{par, data};
    endfunction

    assign par_bad_s = parity_bad(cfg_par, cfg_data);
`else
    logic unused_par_s;
    assign unused_par_s = cfg_par;
    assign par_bad_s    = 1'b0;
`endif

    // Staging image with the current word placed at slot wcnt. Word bits that
    // would land at or above CFG_W have no destination and are dropped.
    always_comb begin
        stage_merge_s = stage_r;
        for (int i = 0; i < CFG_W; i++) begin
            if ((i / WORD_W) == int'(wcnt_r)) begin
                stage_merge_s[i] = cfg_data[i % WORD_W];
            end else begin
                stage_merge_s[i] = stage_r[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: sequencing and frame checks.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!accept_s) begin
                    state_nxt_s = ST_LOAD;
                end else if (par_bad_s) begin
                    state_nxt_s = cfg_last ? ST_IDLE : ST_DRAIN;
                end else if (cfg_last && !final_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (final_s) begin
                    state_nxt_s = cfg_last ? ST_COMMIT : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (accept_s && cfg_last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values. The flags are computed from the next
    // state so that the registered outputs line up with the FSM state.
    // config_out is loaded on the edge that enters COMMIT, so it is already
    // valid while cen is high.
    always_comb begin
        wcnt_nxt_s   = wcnt_r;
        stage_nxt_s  = stage_r;
        config_nxt_s = config_r;
        err_nxt_s    = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    err_nxt_s  = 1'b0;
                    wcnt_nxt_s = {WCNT_W{1'b0}};
                end else begin
                    err_nxt_s  = err_r;
                end
            end
            ST_LOAD: begin
                if (!accept_s) begin
                    wcnt_nxt_s = wcnt_r;
                end else if (par_bad_s) begin
                    err_nxt_s = 1'b1;
                end else if (cfg_last && !final_s) begin
                    err_nxt_s = 1'b1;
                end else if (final_s) begin
                    stage_nxt_s = stage_merge_s;
                    if (cfg_last) begin
                        config_nxt_s = stage_merge_s;
                    end else begin
                        err_nxt_s = 1'b1;
                    end
                end else begin
                    stage_nxt_s = stage_merge_s;
                    wcnt_nxt_s  = wcnt_r + WCNT_W'(1);
                end
            end
            ST_COMMIT: begin
                err_nxt_s = err_r;
            end
            ST_DRAIN: begin
                err_nxt_s = err_r;
            end
            default: begin
                err_nxt_s = err_r;
            end
        endcase

        cen_nxt_s   = (state_nxt_s == ST_COMMIT);
        ready_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_DRAIN);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        done_nxt_s  = (state_r == ST_COMMIT);
    end

    // Datapath and output registers.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            wcnt_r   <= {WCNT_W{1'b0}};
            stage_r  <= {CFG_W{1'b0}};
            config_r <= {CFG_W{1'b0}};
            cen_r    <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wcnt_r   <= wcnt_nxt_s;
            stage_r  <= stage_nxt_s;
            config_r <= config_nxt_s;
            cen_r    <= cen_nxt_s;
            ready_r  <= ready_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Testbench for lut_cfg_loader (INPUTS=4: CFG_W=33, NWORDS=5).
// Expected images are pushed to a queue when a frame is driven and popped
// when the loader strobes cen.
module tb_lut_cfg_loader;

    localparam int CFG_W  = 33;
    localparam int WORD_W = 8;

    logic              cclk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_last;
    logic              cfg_par;
    logic              cen;
    logic [CFG_W-1:0]  config_out;
    logic              busy;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]       words [0:7];
    logic [CFG_W-1:0] exp_q [$];
    logic [CFG_W-1:0] last_cfg;
    int               cen_seen = 0;
    int               done_seen = 0;
    logic [CFG_W-1:0] cen_cap = '0;

    lut_cfg_loader dut (
        .cclk(cclk), .rst_n(rst_n), .start(start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .cfg_par(cfg_par), .cen(cen),
        .config_out(config_out), .busy(busy), .done(done), .err(err)
    );

    always #5 cclk = ~cclk;

    // Count strobe cycles and capture the image seen while cen is high.
    always @(negedge cclk) begin
        if (cen === 1'b1) begin
            cen_seen <= cen_seen + 1;
            cen_cap  <= config_out;
        end
        if (done === 1'b1) begin
            done_seen <= done_seen + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Reference image: words packed LSB-first into 40 bits, top bits dropped.
    function automatic logic [CFG_W-1:0] model_img();
        logic [39:0] t;
        t = 40'd0;
        for (int k = 0; k < 5; k++) t[k*8 +: 8] = words[k];
        return t[CFG_W-1:0];
    endfunction

    task automatic set_words(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                             input logic [7:0] w3, input logic [7:0] w4, input logic [7:0] w5,
                             input logic [7:0] w6);
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        words[4] = w4; words[5] = w5; words[6] = w6; words[7] = 8'h00;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Send words[first .. first+n-1]; each is held until accepted, then
    // 'gap' idle cycles follow. Word bad_idx is sent with inverted parity.
    task automatic send_words(input int first, input int n, input int last_idx,
                              input int gap, input int bad_idx);
        for (int k = first; k < first + n; k++) begin
            int t;
            cfg_data  = words[k];
            cfg_last  = (k == last_idx);
            cfg_par   = (^words[k]) ^ (k == bad_idx);
            cfg_valid = 1'b1;
            t = 0;
            while (cfg_ready !== 1'b1 && t < 10) begin
                tick();
                t++;
            end
            vectors++;
            if (t >= 10) begin
                miscompares++;
                $display("FAIL ready_wait word=%0d cfg_ready=%b required=1", k, cfg_ready);
            end
            tick();
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Wait (bounded) for a commit, then check pulse counts and the image.
    task automatic wait_commit(input string name, input int c0, input int d0);
        int t;
        logic [CFG_W-1:0] e;
        t = 0;
        while (cen_seen == c0 && t < 40) begin
            tick();
            t++;
        end
        tick();
        tick();
        vectors++;
        if (cen_seen - c0 != 1) begin
            miscompares++;
            $display("FAIL %s_cen_cycles got=%0d required=1", name, cen_seen - c0);
        end
        vectors++;
        if (done_seen - d0 != 1) begin
            miscompares++;
            $display("FAIL %s_done_cycles got=%0d required=1", name, done_seen - d0);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s_scoreboard_empty got=0 required=1 entry", name);
        end else begin
            e = exp_q.pop_front();
            if (cen_cap !== e || config_out !== e || err !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_image got=%h/%h err=%b required=%h err=0", name, cen_cap, config_out, err, e);
            end
            last_cfg = e;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({cen, cfg_ready, busy, done, err} !== 5'b00000 || config_out !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_values got=%b cfg=%h required=00000 cfg=0",
                     {cen, cfg_ready, busy, done, err}, config_out);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({cen, cfg_ready, busy, done, err} !== 5'b00000) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%b required=00000", {cen, cfg_ready, busy, done, err});
        end
        last_cfg = 33'd0;
    endtask

    task automatic test_nominal();
        int c0;
        logic [CFG_W-1:0] e;
        set_words(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen;
        do_start();
        vectors++;
        if ({cfg_ready, busy, cen} !== 3'b110) begin
            miscompares++;
            $display("FAIL nominal_load_entry got=%b required=110", {cfg_ready, busy, cen});
        end
        cfg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cfg_data = words[k];
            cfg_last = (k == 4);
            cfg_par  = ^words[k];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (cen !== 1'b1 || done !== 1'b0 || cen_seen != c0 || config_out !== e) begin
            miscompares++;
            $display("FAIL nominal_cen_cycle got cen=%b done=%b early=%0d cfg=%h required cen=1 done=0 early=0 cfg=%h",
                     cen, done, cen_seen - c0, config_out, e);
        end
        vectors++;
        if (config_out !== 33'h1_DEADBEEF) begin
            miscompares++;
            $display("FAIL nominal_image got=%h required=1deadbeef", config_out);
        end
        tick();
        vectors++;
        if ({cen, done, err, busy} !== 4'b0100 || config_out !== e) begin
            miscompares++;
            $display("FAIL nominal_done_cycle got=%b cfg=%h required=0100 cfg=%h", {cen, done, err, busy}, config_out, e);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || cen_seen - c0 != 1) begin
            miscompares++;
            $display("FAIL nominal_after got done=%b pulses=%0d required done=0 pulses=1", done, cen_seen - c0);
        end
        last_cfg = e;
    endtask

    task automatic test_backpressure();
        int c0, d0;
        set_words(8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        send_words(0, 5, 4, 3, -1);
        wait_commit("backpressure", c0, d0);
    endtask

    task automatic test_packing();
        int c0, d0;
        set_words(8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        send_words(0, 5, 4, 0, -1);
        wait_commit("packing", c0, d0);
        vectors++;
        if (config_out[32] !== 1'b1 || config_out !== 33'h1_44332211) begin
            miscompares++;
            $display("FAIL packing_split_bit got=%h required=144332211", config_out);
        end
    endtask

    task automatic test_early_last();
        int c0, d0;
        set_words(8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00);
        c0 = cen_seen;
        do_start();
        send_words(0, 3, 2, 0, -1);
        vectors++;
        if ({err, busy, cfg_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL early_last_state got=%b required=100", {err, busy, cfg_ready});
        end
        repeat (4) tick();
        vectors++;
        if (cen_seen != c0 || config_out !== last_cfg || err !== 1'b1) begin
            miscompares++;
            $display("FAIL early_last_hold got pulses=%0d cfg=%h err=%b required pulses=0 cfg=%h err=1",
                     cen_seen - c0, config_out, err, last_cfg);
        end
        set_words(8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL early_last_err_clear got=%b required=0", err);
        end
        send_words(0, 5, 4, 0, -1);
        wait_commit("after_early_last", c0, d0);
    endtask

    task automatic test_overlong();
        int c0;
        set_words(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07);
        c0 = cen_seen;
        do_start();
        send_words(0, 5, -1, 0, -1);
        vectors++;
        if ({busy, cfg_ready, err} !== 3'b111) begin
            miscompares++;
            $display("FAIL overlong_drain_entry got=%b required=111", {busy, cfg_ready, err});
        end
        send_words(5, 1, -1, 0, -1);
        vectors++;
        if ({busy, cfg_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL overlong_draining got=%b required=11", {busy, cfg_ready});
        end
        send_words(6, 1, 6, 0, -1);
        vectors++;
        if ({busy, cfg_ready, err} !== 3'b001) begin
            miscompares++;
            $display("FAIL overlong_exit got=%b required=001", {busy, cfg_ready, err});
        end
        repeat (3) tick();
        vectors++;
        if (cen_seen != c0 || config_out !== last_cfg) begin
            miscompares++;
            $display("FAIL overlong_no_commit got pulses=%0d cfg=%h required pulses=0 cfg=%h",
                     cen_seen - c0, config_out, last_cfg);
        end
    endtask

    task automatic test_reset_mid();
        int c0, d0;
        set_words(8'h99, 8'h88, 8'h77, 8'h66, 8'h00, 8'h00, 8'h00);
        c0 = cen_seen;
        do_start();
        send_words(0, 4, -1, 0, -1);
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({cen, cfg_ready, busy, done, err} !== 5'b00000 || config_out !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_mid_values got=%b cfg=%h required=00000 cfg=0",
                     {cen, cfg_ready, busy, done, err}, config_out);
        end
        rst_n = 1'b1;
        last_cfg = 33'd0;
        cfg_valid = 1'b1;
        repeat (3) tick();
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== 1'b0 || cen_seen != c0) begin
            miscompares++;
            $display("FAIL reset_mid_needs_start got ready=%b pulses=%0d required ready=0 pulses=0",
                     cfg_ready, cen_seen - c0);
        end
        set_words(8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        send_words(0, 5, 4, 1, -1);
        wait_commit("after_reset_mid", c0, d0);
    endtask

`ifdef LUT_CFG_PARITY_EN
    task automatic test_parity();
        int c0, d0;
        set_words(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h01, 8'h00, 8'h00);
        c0 = cen_seen;
        do_start();
        send_words(0, 2, -1, 0, 1);
        vectors++;
        if ({busy, cfg_ready, err} !== 3'b111) begin
            miscompares++;
            $display("FAIL parity_bad_drain got=%b required=111", {busy, cfg_ready, err});
        end
        send_words(2, 3, 4, 0, -1);
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1 || cen_seen != c0 || config_out !== last_cfg) begin
            miscompares++;
            $display("FAIL parity_bad_no_commit got busy=%b err=%b pulses=%0d cfg=%h required 0 1 0 %h",
                     busy, err, cen_seen - c0, config_out, last_cfg);
        end
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        send_words(0, 5, 4, 0, -1);
        wait_commit("parity_good", c0, d0);
    endtask
`else
    task automatic test_parity();
        int c0, d0;
        set_words(8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h01, 8'h00, 8'h00);
        exp_q.push_back(model_img());
        c0 = cen_seen; d0 = done_seen;
        do_start();
        send_words(0, 5, 4, 0, 1);
        wait_commit("parity_ignored", c0, d0);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_par   = 1'b0;
        cfg_data  = 8'h00;
        repeat (3) tick();
        test_reset();
        test_nominal();
        test_backpressure();
        test_packing();
        test_early_last();
        test_overlong();
        test_reset_mid();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
